// File: rtl/image_rom_scanner_pkg.sv
// Shared image constants, scanner state encoding and the per-pixel flag layout.
package image_rom_scanner_pkg;

  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 156;
  localparam int DEF_DATA_WIDTH = 8;

  localparam int FLAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } flags_t;

  // Counter width that stays legal for a range of a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_rom_scanner_if.sv
// ROM read port plus the outgoing valid/ready pixel stream with frame/line markers.
interface image_rom_scanner_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
);
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sof;
  logic                  m_eol;
  logic                  m_eof;

  modport master (
    output rom_en, rom_addr, m_data, m_valid, m_sof, m_eol, m_eof,
    input  rom_data, m_ready
  );

  modport slave (
    input  rom_en, rom_addr, m_data, m_valid, m_sof, m_eol, m_eof,
    output rom_data, m_ready
  );
endinterface

// File: rtl/image_rom_scanner_pix_fifo.sv
// Show-ahead synchronous FIFO, 0-cycle read of head, 1-cycle write-to-visible.
// A write is accepted while full only when the head is popped in the same cycle.
module pix_fifo
  import image_rom_scanner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  parameter int CW    = cnt_w(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_rdy,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);
  localparam int             PW     = cnt_w(DEPTH);
  localparam logic [PW-1:0]  P_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd;
  logic             w_wr;

  assign w_rd = i_rd_rdy && (r_count != '0);
  assign w_wr = i_wr_vld && ((r_count != C_FULL) || w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/image_rom_scanner.sv
// Raster-order ROM reader feeding a valid/ready pixel stream; first pixel 3 cycles after start.
// Reads are issued only against free FIFO credit, so back-pressure never drops or repeats pixels.
module image_rom_scanner
  import image_rom_scanner_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_continuous,
  output logic o_busy,
  output logic o_done,
  image_rom_scanner_if.master bus
);
  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
  localparam int CW = cnt_w(FIFO_DEPTH + 1);
  localparam int FW = DATA_WIDTH + FLAG_W;
  localparam logic [XW-1:0]         X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] A_BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW:0]           CREDITS = (CW + 1)'(FIFO_DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_vld;
  flags_t                r_rd_flags;
  logic                  r_done;

  logic                  w_last_x;
  logic                  w_last_y;
  logic                  w_last_pix;
  logic                  w_issue;
  flags_t                w_issue_flags;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_used;
  logic                  w_empty;
  logic [FW-1:0]         w_head;
  flags_t                w_head_flags;
  logic                  w_pop;
  logic                  w_eof_pop;
  logic                  w_final_pop;

  assign w_last_x   = (r_x == X_LAST);
  assign w_last_y   = (r_y == Y_LAST);
  assign w_last_pix = w_last_x && w_last_y;

  // Credit: buffered entries plus the read still in the ROM pipeline.
  assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_rd_vld};
  assign w_issue = (r_state == ST_RUN) && (w_used < CREDITS);

  assign w_issue_flags.sof = (r_x == '0) && (r_y == '0);
  assign w_issue_flags.eol = w_last_x;
  assign w_issue_flags.eof = w_last_pix;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW),
    .CW    (CW)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_vld (r_rd_vld),
    .i_wr_dat ({bus.rom_data, r_rd_flags}),
    .i_rd_rdy (bus.m_ready),
    .o_rd_dat (w_head),
    .o_count  (w_count),
    .o_empty  (w_empty)
  );

  assign w_head_flags = flags_t'(w_head[FLAG_W-1:0]);
  assign w_pop        = !w_empty && bus.m_ready;
  assign w_eof_pop    = w_pop && w_head_flags.eof;
  // In DRAIN the last outstanding pixel is the one closing the frame.
  assign w_final_pop  = w_eof_pop && (w_count == CW'(1)) && !r_rd_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue && w_last_pix && !i_continuous) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_final_pop) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= A_BASE;
    end else if (w_issue) begin
      r_x    <= w_last_x ? '0 : r_x + XW'(1);
      if (w_last_x) r_y <= w_last_y ? '0 : r_y + YW'(1);
      r_addr <= w_last_pix ? A_BASE : r_addr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_vld   <= 1'b0;
      r_rd_flags <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rd_vld   <= w_issue;
      r_rd_flags <= w_issue_flags;
      r_done     <= w_eof_pop;
    end
  end

  assign bus.rom_en   = w_issue;
  assign bus.rom_addr = r_addr;
  assign bus.m_valid  = !w_empty;
  assign bus.m_data   = w_empty ? '0 : w_head[FW-1:FLAG_W];
  assign bus.m_sof    = !w_empty && w_head_flags.sof;
  assign bus.m_eol    = !w_empty && w_head_flags.eol;
  assign bus.m_eof    = !w_empty && w_head_flags.eof;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;

endmodule

// File: doc/image_rom_scanner.md
# image_rom_scanner

Sequencer that reads a stored image out of a synchronous image ROM in raster order and presents it as a valid/ready pixel stream with frame and line markers. It owns the ROM address and enable, absorbs the ROM's one-cycle read latency, and tolerates downstream back-pressure without losing or duplicating pixels. It sits between the image ROM and the first processing stage of the image pipeline.

## Interface
- ADDR_WIDTH, 17, ROM address width
- DATA_WIDTH, 8, pixel width
- IMG_WIDTH, 320, pixels per line, at least 1
- IMG_HEIGHT, 156, lines per frame, at least 1; IMG_WIDTH*IMG_HEIGHT must fit within the ROM depth
- BASE_ADDR, 0, ROM address of pixel (0,0)
- FIFO_DEPTH, 4, output buffer entries, at least 2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; ignored while busy=1
- continuous  in  1  when 1, the next frame starts with no gap
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH  ROM output, valid the cycle after rom_en
- m_data  out  DATA_WIDTH  pixel
- m_valid  out  1  pixel available
- m_ready  in  1  sink accepts the pixel
- m_sof  out  1  pixel is (0,0)
- m_eol  out  1  pixel is the last pixel of its line
- m_eof  out  1  pixel is the last pixel of the frame
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse after the final pixel is accepted

## Operation
- The reset value of every output is 0, and rom_addr resets to 0.
- The state machine has three states:
  - IDLE goes to RUN when start=1; x, y and the issue address load 0 and BASE_ADDR.
  - RUN issues reads. It goes to DRAIN when it issues the last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) and continuous=0 in that cycle.
  - DRAIN goes to IDLE on the handshake of the eof pixel.
- Issue rule: in RUN, assert rom_en when occupancy + in_flight < FIFO_DEPTH. in_flight is 0 or 1. Every rom_en produces exactly one FIFO write one cycle later.
- Sideband: the sof, eol and eof flags are computed from x and y at issue time and delayed one cycle alongside the read, so each flag is written into the same FIFO entry as its pixel.
- Counters:
  - On issue, x increments. At IMG_WIDTH-1, x wraps to 0 and y increments. At the last pixel, x and y wrap to 0.
  - The address increments by 1 and wraps to BASE_ADDR at the end of the frame.
  - The address arithmetic is ADDR_WIDTH bits wide and never exceeds BASE_ADDR + IMG_WIDTH*IMG_HEIGHT - 1.
- Continuous mode: when continuous=1 at the last issue, RUN continues straight into the next frame. In this mode done still pulses on each eof handshake.
- Handshake:
  - A pixel transfers when m_valid=1 and m_ready=1.
  - While m_valid=1 and m_ready=0, m_data and all flags stay stable.
  - m_valid never drops without a handshake.
- busy is 1 from the cycle after start is accepted until the cycle after the eof handshake in DRAIN.
- done is registered: it pulses in the cycle after the eof handshake.
- Reset mid-frame: all state clears immediately. The partial frame is discarded, with no eof and no done.
- IMG_WIDTH=1: every pixel has eol=1. A 1x1 image gives sof=eol=eof=1 on a single pixel.

## Timing
- start is sampled at edge k. rom_en=1 with rom_addr=BASE_ADDR in cycle k+1. rom_data is valid in k+2 and written at the end of k+2. m_valid=1 in k+3.
- With m_ready held at 1, the stream runs at 1 pixel/clock with no bubbles, including across frame boundaries in continuous mode.
- From the last handshake to IDLE takes 1 cycle. A new start is accepted the cycle busy falls.
- rom_en is never asserted in IDLE or DRAIN.

## Structure
- The shared image package holds:
  - the default IMG_WIDTH, IMG_HEIGHT and DATA_WIDTH constants;
  - the state encoding (IDLE, RUN, DRAIN);
  - the layout of the 3-bit flag field (sof, eol, eof).
- One sub-module, pix_fifo: a synchronous FIFO FIFO_DEPTH deep and DATA_WIDTH+3 bits wide, providing a count output, show-ahead read and simultaneous read/write when full. The scanner holds the FSM, the counters and the credit logic.

## Test plan
- Basic frame (IMG_WIDTH=4, IMG_HEIGHT=2, ROM[i]=i, m_ready=1, start pulse):
  - 8 pixels 0..7 on consecutive cycles, the first at k+3;
  - sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7;
  - done pulses one cycle after pixel 7, then busy=0.
- Back-pressure (same frame, m_ready random at 50%, plus a 10-cycle stall after pixel 2): the sink receives exactly 0..7 in order, and m_data is stable whenever m_valid=1 and m_ready=0.
- Continuous (continuous=1, 3 frames, m_ready=1):
  - 24 gapless pixels, 0..7 repeated three times, with three done pulses;
  - continuous is then dropped before the third frame's last issue, and busy falls after it.
- Start ignored while busy (start pulsed again at pixel 4): exactly 8 pixels are output, with no restart.
- Reset mid-frame (rst asserted after pixel 5, then start): all outputs are 0 during reset, and the next frame begins with pixel 0 and sof=1.
- 1x1 image: one pixel with sof=eol=eof=1, followed by a done pulse.
